// File: rtl/instr_encoder_pkg.sv
// Shared encoding definitions: MIPS opcode/funct constants, symbolic
// mnemonic enum, error codes and small word-assembly helpers.
package instr_encoder_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // Symbolic mnemonics; codes 30 and 31 are illegal
    typedef enum logic [4:0] {
        MN_ADD   = 5'd0,  MN_ADDU  = 5'd1,  MN_SUB   = 5'd2,  MN_SUBU  = 5'd3,
        MN_AND   = 5'd4,  MN_OR    = 5'd5,  MN_XOR   = 5'd6,  MN_NOR   = 5'd7,
        MN_SLT   = 5'd8,  MN_SLTU  = 5'd9,  MN_SLL   = 5'd10, MN_SRL   = 5'd11,
        MN_SRA   = 5'd12, MN_SLLV  = 5'd13, MN_SRLV  = 5'd14, MN_SRAV  = 5'd15,
        MN_ADDI  = 5'd16, MN_ADDIU = 5'd17, MN_SLTI  = 5'd18, MN_SLTIU = 5'd19,
        MN_ANDI  = 5'd20, MN_ORI   = 5'd21, MN_XORI  = 5'd22, MN_LUI   = 5'd23,
        MN_LW    = 5'd24, MN_SW    = 5'd25, MN_BEQ   = 5'd26, MN_BNE   = 5'd27,
        MN_J     = 5'd28, MN_JAL   = 5'd29
    } mnem_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ILLEGAL = 2'b01,
        ERR_BRANCH  = 2'b10,
        ERR_JUMP    = 2'b11
    } err_e;

    function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] shamt,
                                           input logic [5:0] funct);
        return {OP_RTYPE, rs, rt, rd, shamt, funct};
    endfunction

    function automatic logic [31:0] i_word(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] j_word(input logic [5:0] op, input logic [25:0] index);
        return {op, index};
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// Combinational packer: symbolic instruction + current PC -> 32-bit MIPS
// word, plus illegal / branch-range / jump-region error flags.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [4:0]  mnem_i,
    input  logic [4:0]  rs_i,
    input  logic [4:0]  rt_i,
    input  logic [4:0]  rd_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] target_i,
    input  logic [31:0] pc_i,
    output logic [31:0] word_o,
    output logic        illegal_o,
    output logic        br_err_o,
    output logic        j_err_o
);

    logic [31:0] pc_plus4;
    logic [31:0] br_diff;
    logic        br_bad;
    logic        j_bad;

    // Branch offsets are relative to the delay-slot address; the word offset
    // fits in 16 bits only when diff[31:17] is a pure sign extension.
    assign pc_plus4 = pc_i + 32'd4;
    assign br_diff  = target_i - pc_plus4;
    assign br_bad   = (br_diff[1:0] != 2'b00) ||
                      !((&br_diff[31:17]) || (~|br_diff[31:17]));
    assign j_bad    = (target_i[1:0] != 2'b00) || (target_i[31:28] != pc_plus4[31:28]);

    // Select encoding format and fields per mnemonic
    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        word_o    = '0;
        illegal_o = 1'b0;
        br_err_o  = 1'b0;
        j_err_o   = 1'b0;
        case (mnem_i)
            MN_ADD:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADD);
            MN_ADDU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_ADDU);
            MN_SUB:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUB);
            MN_SUBU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SUBU);
            MN_AND:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_AND);
            MN_OR:    word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_OR);
            MN_XOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_XOR);
            MN_NOR:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_NOR);
            MN_SLT:   word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLT);
            MN_SLTU:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLTU);
            MN_SLL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SLL);
            MN_SRL:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRL);
            MN_SRA:   word_o = r_word(5'd0, rt_i, rd_i, shamt_i, FN_SRA);
            MN_SLLV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SLLV);
            MN_SRLV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SRLV);
            MN_SRAV:  word_o = r_word(rs_i, rt_i, rd_i, 5'd0, FN_SRAV);
            MN_ADDI:  word_o = i_word(OP_ADDI, rs_i, rt_i, imm_i);
            MN_ADDIU: word_o = i_word(OP_ADDIU, rs_i, rt_i, imm_i);
            MN_SLTI:  word_o = i_word(OP_SLTI, rs_i, rt_i, imm_i);
            MN_SLTIU: word_o = i_word(OP_SLTIU, rs_i, rt_i, imm_i);
            MN_ANDI:  word_o = i_word(OP_ANDI, rs_i, rt_i, imm_i);
            MN_ORI:   word_o = i_word(OP_ORI, rs_i, rt_i, imm_i);
            MN_XORI:  word_o = i_word(OP_XORI, rs_i, rt_i, imm_i);
            MN_LUI:   word_o = i_word(OP_LUI, 5'd0, rt_i, imm_i);
            MN_LW:    word_o = i_word(OP_LW, rs_i, rt_i, imm_i);
            MN_SW:    word_o = i_word(OP_SW, rs_i, rt_i, imm_i);
            MN_BEQ: begin
                word_o   = i_word(OP_BEQ, rs_i, rt_i, br_diff[17:2]);
                br_err_o = br_bad;
            end
            MN_BNE: begin
                word_o   = i_word(OP_BNE, rs_i, rt_i, br_diff[17:2]);
                br_err_o = br_bad;
            end
            MN_J: begin
                word_o  = j_word(OP_J, target_i[27:2]);
                j_err_o = j_bad;
            end
            MN_JAL: begin
                word_o  = j_word(OP_JAL, target_i[27:2]);
                j_err_o = j_bad;
            end
            default:  illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder: valid/ready input of symbolic instructions, one
// output register stage writing encoded words to instruction memory at an
// auto-incrementing PC, with write counter and sticky first-error capture.
module instr_encoder
    import instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             restart,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_mnem,
    input  logic [4:0]       in_rs,
    input  logic [4:0]       in_rt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_shamt,
    input  logic [15:0]      in_imm,
    input  logic [31:0]      in_target,
    output logic             im_we,
    input  logic             im_ready,
    output logic [31:0]      im_addr,
    output logic [31:0]      im_wdata,
    output logic [31:0]      pc,
    output logic [CNT_W-1:0] count,
    output logic             err,
    output logic [1:0]       err_code
);

    logic             we_q, we_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    err_e             err_code_q, err_code_d;

    logic [31:0] pack_word;
    logic        pack_illegal, pack_br_err, pack_j_err, pack_err;
    logic        accept, write_done;
    err_e        new_code;

    instr_pack u_pack (
        .mnem_i    (in_mnem),
        .rs_i      (in_rs),
        .rt_i      (in_rt),
        .rd_i      (in_rd),
        .shamt_i   (in_shamt),
        .imm_i     (in_imm),
        .target_i  (in_target),
        .pc_i      (pc_q),
        .word_o    (pack_word),
        .illegal_o (pack_illegal),
        .br_err_o  (pack_br_err),
        .j_err_o   (pack_j_err)
    );

    // Ready when not flushing and the output slot is empty or draining now
    assign in_ready   = !rst && !restart && (!we_q || im_ready);
    assign accept     = in_valid && in_ready;
    assign write_done = we_q && im_ready;
    assign pack_err   = pack_illegal || pack_br_err || pack_j_err;
    assign new_code   = pack_illegal ? ERR_ILLEGAL : (pack_br_err ? ERR_BRANCH : ERR_JUMP);

    // Next-state: retire completed write, load a new word or record an error
    always_comb begin
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pc_d       = pc_q;
        count_d    = count_q;
        err_d      = err_q;
        err_code_d = err_code_q;
        if (write_done) begin
            we_d    = 1'b0;
            count_d = count_q + CNT_W'(1);
        end
        if (accept) begin
            if (pack_err) begin
                err_d = 1'b1;
                if (!err_q) begin
                    err_code_d = new_code;
                end
            end else begin
                we_d    = 1'b1;
                addr_d  = pc_q;
                wdata_d = pack_word;
                pc_d    = pc_q + 32'd4;
            end
        end
    end

    // State registers: reset, then restart flush, then normal update
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pc_q       <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else if (restart) begin
            we_q       <= 1'b0;
            pc_q       <= BASE_ADDR;
            count_q    <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pc_q       <= pc_d;
            count_q    <= count_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign im_we    = we_q;
    assign im_addr  = addr_q;
    assign im_wdata = wdata_q;
    assign pc       = pc_q;
    assign count    = count_q;
    assign err      = err_q;
    assign err_code = err_code_q;

endmodule
